// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Two-master (IFU/LSU) to one-slave memory port arbiter with one
//            outstanding transaction and a response-timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int LSU_PRIORITY   = 1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_req_addr,
    output logic        ifu_rsp_valid,
    input  logic        ifu_rsp_ready,
    output logic [31:0] ifu_rsp_rdata,
    output logic        ifu_rsp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_req_addr,
    input  logic        lsu_req_wen,
    input  logic [31:0] lsu_req_wdata,
    input  logic [3:0]  lsu_req_wstrb,
    output logic        lsu_rsp_valid,
    input  logic        lsu_rsp_ready,
    output logic [31:0] lsu_rsp_rdata,
    output logic        lsu_rsp_err,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_rdata,
    input  logic        mem_rsp_err,
    output logic [1:0]  grant,
    output logic        busy
);

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_req   = 3'd1;
    localparam logic [2:0] c_rsp   = 3'd2;
    localparam logic [2:0] c_err   = 3'd3;
    localparam logic [2:0] c_flush = 3'd4;

    localparam logic [CNT_W-1:0] c_to_last =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_lsu_q, owner_lsu_d;
    logic             last_lsu_q, last_lsu_d;
    logic [31:0]      mem_req_addr_q, mem_req_addr_d;
    logic             mem_req_wen_q, mem_req_wen_d;
    logic [31:0]      mem_req_wdata_q, mem_req_wdata_d;
    logic [3:0]       mem_req_wstrb_q, mem_req_wstrb_d;

    logic w_pick_lsu;
    logic w_any_req;
    logic w_owner_rsp_ready;
    logic w_timeout;

    // On a tie, fixed priority favours the LSU; round-robin favours whoever
    // did not win last time.
    assign w_pick_lsu = lsu_req_valid &
                        (~ifu_req_valid | (LSU_PRIORITY != 0) | ~last_lsu_q);
    assign w_any_req  = ifu_req_valid | lsu_req_valid;
    assign w_owner_rsp_ready = owner_lsu_q ? lsu_rsp_ready : ifu_rsp_ready;
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (cnt_q == c_to_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= c_idle;
            cnt_q           <= '0;
            owner_lsu_q     <= 1'b0;
            last_lsu_q      <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_req_wen_q   <= 1'b0;
            mem_req_wdata_q <= '0;
            mem_req_wstrb_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            owner_lsu_q     <= owner_lsu_d;
            last_lsu_q      <= last_lsu_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wen_q   <= mem_req_wen_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            mem_req_wstrb_q <= mem_req_wstrb_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        owner_lsu_d     = owner_lsu_q;
        last_lsu_d      = last_lsu_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wen_d   = mem_req_wen_q;
        mem_req_wdata_d = mem_req_wdata_q;
        mem_req_wstrb_d = mem_req_wstrb_q;
        case (state_q)
            c_idle: begin
                if (w_any_req) begin
                    state_d         = c_req;
                    owner_lsu_d     = w_pick_lsu;
                    last_lsu_d      = w_pick_lsu;
                    mem_req_addr_d  = w_pick_lsu ? lsu_req_addr : ifu_req_addr;
                    mem_req_wen_d   = w_pick_lsu & lsu_req_wen;
                    mem_req_wdata_d = w_pick_lsu ? lsu_req_wdata : 32'h0;
                    mem_req_wstrb_d = w_pick_lsu ? lsu_req_wstrb : 4'h0;
                end
            end
            c_req: begin
                if (mem_req_ready) begin
                    state_d = c_rsp;
                    cnt_d   = '0;
                end
            end
            c_rsp: begin
                if (mem_rsp_valid) begin
                    if (w_owner_rsp_ready) begin
                        state_d = c_idle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (w_timeout) begin
                        state_d = c_err;
                    end
                end
            end
            c_err: begin
                if (w_owner_rsp_ready) begin
                    state_d = c_flush;
                end
            end
            c_flush: begin
                if (mem_rsp_valid) begin
                    state_d = c_idle;
                end
            end
            default: state_d = c_idle;
        endcase
    end

    // Every output is forced low while rst is high so a mid-transaction reset
    // is seen immediately by both masters and the slave.
    always_comb begin
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_rdata = 32'h0;
        ifu_rsp_err   = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rsp_rdata = 32'h0;
        lsu_rsp_err   = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        mem_req_addr  = mem_req_addr_q;
        mem_req_wen   = mem_req_wen_q;
        mem_req_wdata = mem_req_wdata_q;
        mem_req_wstrb = mem_req_wstrb_q;
        busy          = (state_q != c_idle);
        grant         = (state_q != c_idle) ? {owner_lsu_q, ~owner_lsu_q} : 2'b00;
        case (state_q)
            c_idle: begin
                lsu_req_ready = w_pick_lsu;
                ifu_req_ready = ifu_req_valid & ~w_pick_lsu;
            end
            c_req: mem_req_valid = 1'b1;
            c_rsp: begin
                mem_rsp_ready = w_owner_rsp_ready;
                if (owner_lsu_q) begin
                    lsu_rsp_valid = mem_rsp_valid;
                    lsu_rsp_rdata = mem_req_wen_q ? 32'h0 : mem_rsp_rdata;
                    lsu_rsp_err   = mem_rsp_err;
                end else begin
                    ifu_rsp_valid = mem_rsp_valid;
                    ifu_rsp_rdata = mem_rsp_rdata;
                    ifu_rsp_err   = mem_rsp_err;
                end
            end
            c_err: begin
                lsu_rsp_valid = owner_lsu_q;
                lsu_rsp_err   = owner_lsu_q;
                ifu_rsp_valid = ~owner_lsu_q;
                ifu_rsp_err   = ~owner_lsu_q;
            end
            c_flush: mem_rsp_ready = 1'b1;
            default: ;
        endcase
        if (rst) begin
            ifu_req_ready = 1'b0;
            lsu_req_ready = 1'b0;
            ifu_rsp_valid = 1'b0;
            ifu_rsp_rdata = 32'h0;
            ifu_rsp_err   = 1'b0;
            lsu_rsp_valid = 1'b0;
            lsu_rsp_rdata = 32'h0;
            lsu_rsp_err   = 1'b0;
            mem_req_valid = 1'b0;
            mem_rsp_ready = 1'b0;
            mem_req_addr  = 32'h0;
            mem_req_wen   = 1'b0;
            mem_req_wdata = 32'h0;
            mem_req_wstrb = 4'h0;
            busy          = 1'b0;
            grant         = 2'b00;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed self-checking bench; instance a is fixed-priority with an
//            8-cycle watchdog, instance b is round-robin on the same inputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_rsp_ready;
    logic [31:0] ifu_req_addr;
    logic        lsu_req_valid, lsu_req_wen, lsu_rsp_ready;
    logic [31:0] lsu_req_addr, lsu_req_wdata;
    logic [3:0]  lsu_req_wstrb;
    logic        mem_req_ready, mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_rsp_rdata;

    logic        ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
    logic [31:0] ifu_rsp_rdata;
    logic        lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
    logic [31:0] lsu_rsp_rdata;
    logic        mem_req_valid, mem_req_wen, mem_rsp_ready, busy;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic [1:0]  grant;

    logic        b_ifu_req_ready, b_ifu_rsp_valid, b_ifu_rsp_err;
    logic [31:0] b_ifu_rsp_rdata;
    logic        b_lsu_req_ready, b_lsu_rsp_valid, b_lsu_rsp_err;
    logic [31:0] b_lsu_rsp_rdata;
    logic        b_mem_req_valid, b_mem_req_wen, b_mem_rsp_ready, b_busy;
    logic [31:0] b_mem_req_addr, b_mem_req_wdata;
    logic [3:0]  b_mem_req_wstrb;
    logic [1:0]  b_grant;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.LSU_PRIORITY(1), .TIMEOUT_CYCLES(8), .CNT_W(11)) u_dut_a (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
        .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .grant(grant), .busy(busy)
    );

    mem_bus_arbiter #(.LSU_PRIORITY(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(b_ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_rsp_valid(b_ifu_rsp_valid),
        .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(b_ifu_rsp_rdata),
        .ifu_rsp_err(b_ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(b_lsu_req_ready),
        .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_rsp_valid(b_lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rsp_rdata(b_lsu_rsp_rdata), .lsu_rsp_err(b_lsu_rsp_err),
        .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(b_mem_req_addr), .mem_req_wen(b_mem_req_wen),
        .mem_req_wdata(b_mem_req_wdata), .mem_req_wstrb(b_mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(b_mem_rsp_ready),
        .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err),
        .grant(b_grant), .busy(b_busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_valid = 0; ifu_req_addr = 0; ifu_rsp_ready = 0;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0;
        lsu_req_wdata = 0; lsu_req_wstrb = 0; lsu_rsp_ready = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_err = 0; mem_rsp_rdata = 0;
        tick(); tick();

        // Outputs held low while rst is asserted, even with a pending request
        ifu_req_valid = 1; #1;
        check_val("rst_ifu_req_ready", 32'(ifu_req_ready), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_grant", 32'(grant), 32'h0);
        check_val("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
        rst = 0; ifu_req_valid = 0;
        tick();

        // Single IFU read
        ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000; #1;
        check_val("t1_ifu_req_ready", 32'(ifu_req_ready), 32'h1);
        check_val("t1_lsu_req_ready", 32'(lsu_req_ready), 32'h0);
        tick();
        ifu_req_valid = 0; mem_req_ready = 1; #1;
        check_val("t1_mem_req_valid", 32'(mem_req_valid), 32'h1);
        check_val("t1_mem_req_addr", mem_req_addr, 32'h8000_0000);
        check_val("t1_mem_req_wen", 32'(mem_req_wen), 32'h0);
        check_val("t1_grant", 32'(grant), 32'h1);
        tick();
        mem_req_ready = 0; ifu_rsp_ready = 1; #1;
        check_val("t1_rsp_wait", 32'(ifu_rsp_valid), 32'h0);
        tick();
        mem_rsp_valid = 1; mem_rsp_rdata = 32'hDEAD_BEEF; #1;
        check_val("t1_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'h1);
        check_val("t1_ifu_rsp_rdata", ifu_rsp_rdata, 32'hDEAD_BEEF);
        check_val("t1_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'h0);
        check_val("t1_mem_rsp_ready", 32'(mem_rsp_ready), 32'h1);
        tick();
        mem_rsp_valid = 0; ifu_rsp_ready = 0; #1;
        check_val("t1_idle_busy", 32'(busy), 32'h0);
        check_val("t1_idle_grant", 32'(grant), 32'h0);

        // Continuous contention: a always picks LSU, b alternates LSU/IFU/LSU
        rst = 1; tick(); rst = 0;
        ifu_req_valid = 1; ifu_req_addr = 32'h0000_1000;
        lsu_req_valid = 1; lsu_req_addr = 32'h0000_0100; lsu_req_wen = 1;
        lsu_req_wdata = 32'h1234_5678; lsu_req_wstrb = 4'hF;
        ifu_rsp_ready = 1; lsu_rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("t2_lsu_req_ready", 32'(lsu_req_ready), 32'h1);
            check_val("t2_ifu_req_ready", 32'(ifu_req_ready), 32'h0);
            check_val("t2_b_lsu_req_ready", 32'(b_lsu_req_ready), (i == 1) ? 32'h0 : 32'h1);
            tick();
            mem_req_ready = 1; #1;
            check_val("t2_grant", 32'(grant), 32'h2);
            check_val("t2_wen", 32'(mem_req_wen), 32'h1);
            check_val("t2_wstrb", 32'(mem_req_wstrb), 32'hF);
            check_val("t2_wdata", mem_req_wdata, 32'h1234_5678);
            check_val("t2_addr", mem_req_addr, 32'h0000_0100);
            check_val("t2_b_grant", 32'(b_grant), (i == 1) ? 32'h1 : 32'h2);
            check_val("t2_b_wen", 32'(b_mem_req_wen), (i == 1) ? 32'h0 : 32'h1);
            tick();
            mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'hFFFF_FFFF; #1;
            check_val("t2_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'h1);
            check_val("t2_lsu_rsp_rdata", lsu_rsp_rdata, 32'h0);
            check_val("t2_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'h0);
            tick();
            mem_rsp_valid = 0;
        end
        ifu_req_valid = 0; lsu_req_valid = 0; lsu_req_wen = 0;
        ifu_rsp_ready = 0; lsu_rsp_ready = 0;
        tick();

        // Backpressure from slave, then from IFU
        ifu_req_valid = 1; ifu_req_addr = 32'h0000_0044; #1;
        check_val("t3_ifu_req_ready", 32'(ifu_req_ready), 32'h1);
        tick();
        ifu_req_valid = 0; ifu_req_addr = 32'hFFFF_FFF0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("t3_req_valid_hold", 32'(mem_req_valid), 32'h1);
            check_val("t3_req_addr_hold", mem_req_addr, 32'h0000_0044);
            tick();
        end
        mem_req_ready = 1; #1;
        check_val("t3_req_valid_acc", 32'(mem_req_valid), 32'h1);
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'hCAFE_0001;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("t3_rsp_valid_stall", 32'(ifu_rsp_valid), 32'h1);
            check_val("t3_mem_rsp_ready_stall", 32'(mem_rsp_ready), 32'h0);
            tick();
        end
        ifu_rsp_ready = 1; #1;
        check_val("t3_mem_rsp_ready", 32'(mem_rsp_ready), 32'h1);
        check_val("t3_ifu_rsp_rdata", ifu_rsp_rdata, 32'hCAFE_0001);
        tick();
        mem_rsp_valid = 0; ifu_rsp_ready = 0; #1;
        check_val("t3_idle_busy", 32'(busy), 32'h0);

        // Watchdog: slave never answers in time
        lsu_req_valid = 1; lsu_req_addr = 32'h0000_0200; #1;
        check_val("t4_lsu_req_ready", 32'(lsu_req_ready), 32'h1);
        tick();
        lsu_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_rsp_rdata = 32'h5555_5555;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_val("t4_rsp_no_valid", 32'(lsu_rsp_valid), 32'h0);
            tick();
        end
        #1;
        check_val("t4_err_valid", 32'(lsu_rsp_valid), 32'h1);
        check_val("t4_err_flag", 32'(lsu_rsp_err), 32'h1);
        check_val("t4_err_rdata", lsu_rsp_rdata, 32'h0);
        mem_rsp_valid = 1; #1;
        check_val("t4_err_mem_rsp_ready", 32'(mem_rsp_ready), 32'h0);
        tick();
        mem_rsp_valid = 0; lsu_rsp_ready = 1; #1;
        check_val("t4_err_hold", 32'(lsu_rsp_valid), 32'h1);
        tick();
        lsu_rsp_ready = 0; ifu_req_valid = 1; ifu_req_addr = 32'h0000_0500;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("t4_flush_mem_rsp_ready", 32'(mem_rsp_ready), 32'h1);
            check_val("t4_flush_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'h0);
            check_val("t4_flush_ifu_req_ready", 32'(ifu_req_ready), 32'h0);
            check_val("t4_flush_grant", 32'(grant), 32'h2);
            tick();
        end
        mem_rsp_valid = 1; #1;
        check_val("t4_flush_drop_lsu", 32'(lsu_rsp_valid), 32'h0);
        check_val("t4_flush_drop_ifu", 32'(ifu_rsp_valid), 32'h0);
        tick();
        mem_rsp_valid = 0; #1;
        check_val("t4_back_idle", 32'(busy), 32'h0);
        check_val("t4_idle_ifu_ready", 32'(ifu_req_ready), 32'h1);
        ifu_req_valid = 0;

        // Reset during RSP
        rst = 1; tick(); rst = 0;
        ifu_req_valid = 1; ifu_req_addr = 32'h0000_0300;
        tick();
        ifu_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_rdata = 32'h0BAD_F00D; #1;
        check_val("t5_rsp_valid_pre", 32'(ifu_rsp_valid), 32'h1);
        rst = 1; #1;
        check_val("t5_rst_rsp_valid", 32'(ifu_rsp_valid), 32'h0);
        tick();
        rst = 0; mem_rsp_valid = 0; #1;
        check_val("t5_busy", 32'(busy), 32'h0);
        check_val("t5_grant", 32'(grant), 32'h0);
        check_val("t5_mem_req_valid", 32'(mem_req_valid), 32'h0);
        check_val("t5_mem_req_addr", mem_req_addr, 32'h0);
        ifu_req_valid = 1; ifu_req_addr = 32'h0000_0400; #1;
        check_val("t5_fresh_ready", 32'(ifu_req_ready), 32'h1);
        tick();
        ifu_req_valid = 0; #1;
        check_val("t5_fresh_valid", 32'(mem_req_valid), 32'h1);
        check_val("t5_fresh_addr", mem_req_addr, 32'h0000_0400);
        check_val("t5_fresh_grant", 32'(grant), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
